serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port Start, input, 1 bit: request to add A and B; sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH bits: operand A, captured on the accepted Start.
REQ-006 SHALL have port B, input, WIDTH bits: operand B, captured on the accepted Start.
REQ-007 SHALL have port Sum, output, WIDTH bits: registered result.
REQ-008 SHALL have port Carry, output, 1 bit: registered carry-out of the MSB.
REQ-009 SHALL have port Busy, output, 1 bit: high while in RUN or DONE.
REQ-010 SHALL have port Done, output, 1 bit: single-cycle result-valid pulse.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE -> RUN on Start=1.
- RUN -> DONE after exactly WIDTH bit-cycles.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-012 SHALL, on Start accepted in IDLE:
- load the A and B shift registers;
- clear the internal carry (or set it, per REQ-024);
- load the bit counter with 0.
REQ-013 SHALL, each RUN cycle, process the current LSBs through one full-adder slice:
- shift A and B right by 1;
- shift the slice sum bit into the result MSB (right shift), so the result is LSB-aligned after WIDTH cycles;
- register the slice carry;
- increment the counter.
REQ-014 SHALL size the bit counter to clog2(WIDTH)+1 bits and SHALL leave RUN when counter == WIDTH-1 is processed, with no wrap-around into an extra cycle.
REQ-015 SHALL, in DONE, drive Done=1 for exactly one cycle, update Sum and Carry from the final result, and hold them until the next accepted Start completes.
REQ-016 SHALL have a latency of WIDTH+1 cycles: Start sampled at edge 0 gives Done high in the cycle after edge WIDTH+1.
REQ-017 SHALL ignore Start while Busy=1, with no operand recapture and no state change. Start held high through DONE is accepted again only once back in IDLE.
REQ-018 SHALL leave Sum and Carry unchanged during RUN; the previous result stays visible.

Reset
REQ-019 SHALL, on rst=1 at a rising clk edge, force state IDLE and clear Sum, Carry, Busy, Done, the shift registers, the counter and the internal carry.
REQ-020 SHALL abort any in-flight addition on reset mid-RUN or mid-DONE: no Done pulse, and outputs read zero the following cycle.
REQ-021 SHALL give rst priority over Start when both are high in the same cycle.

Configuration
REQ-022 SHALL support macro SERIAL_ADDER_SUB_EN.
REQ-023 SHALL, with the macro undefined, have no Sub port and perform addition only.
REQ-024 SHALL, with the macro defined, add input port Sub (1 bit), captured on the accepted Start. When Sub=1, the B bits are inverted into the slice and the initial carry is 1, giving Sum = A-B mod 2^WIDTH with Carry=1 meaning no borrow.

Structure
REQ-025 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH range limits in shared package serial_adder_pkg.
REQ-026 SHALL instantiate exactly one sub-module, bit_full_adder: combinational 1-bit full adder built from two half-adder stages plus an OR, with ports a, b, cin, s, cout.
REQ-027 SHALL use no arithmetic operator on WIDTH-bit vectors; all addition goes through bit_full_adder.

Verification
REQ-028 SHALL cover: WIDTH=8, A=0x5A, B=0x3C, Start pulsed -> Busy high for 9 cycles, Done pulse in cycle 10, Sum=0x96, Carry=0.
REQ-029 SHALL cover: A=0xFF, B=0x01 -> Sum=0x00, Carry=1; then A=0x00, B=0x00 -> Sum=0x00, Carry=0.
REQ-030 SHALL cover: Start re-pulsed with A=0x11, B=0x22 at RUN cycle 3 of 0x5A+0x3C -> ignored, result still 0x96, exactly one Done pulse.
REQ-031 SHALL cover: rst asserted at RUN cycle 4 -> next cycle IDLE, Sum=0, Carry=0, Busy=0, no Done; a fresh Start afterwards completes normally.
REQ-032 SHALL cover, with SERIAL_ADDER_SUB_EN defined: A=0x05, B=0x07, Sub=1 -> Sum=0xFE, Carry=0; A=0x07, B=0x05, Sub=1 -> Sum=0x02, Carry=1.
REQ-033 SHALL cover: Start held high continuously -> back-to-back operations, one every WIDTH+2 cycles, each with a single Done pulse.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM encoding and WIDTH limits for serial_adder_ctrl
package serial_adder_pkg;

  // Legal operand widths for serial_adder_ctrl
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_full_adder.sv
// rtl/bit_full_adder.sv - combinational 1-bit full adder from two half-adder stages and an OR
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  // First half adder combines the operand bits
  assign w_s1 = a ^ b;
  assign w_c1 = a & b;

  // Second half adder folds in the incoming carry
  assign s    = w_s1 ^ cin;
  assign w_c2 = w_s1 & cin;

  // Either half-adder stage can generate the carry-out
  assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller; define SERIAL_ADDER_SUB_EN to add the Sub port
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Busy,
  output logic             Done
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_c;

  logic             w_b_in;
  logic             w_c_init;
  logic             w_s;
  logic             w_cout;

`ifdef SERIAL_ADDER_SUB_EN
  logic             r_sub;

  // Subtraction feeds inverted B bits and starts with carry set (two's complement)
  assign w_b_in   = r_b[0] ^ r_sub;
  assign w_c_init = Sub;
`else
  assign w_b_in   = r_b[0];
  assign w_c_init = 1'b0;
`endif

  bit_full_adder u_fa (
    .a    (r_a[0]),
    .b    (w_b_in),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_cout)
  );

`ifdef SERIAL_ADDER_SUB_EN
  // Capture the operation select with the operands; held for the whole run
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (r_state == IDLE && Start) begin
      r_sub <= Sub;
    end
  end
`endif

  // Controller FSM: load on Start, one bit per RUN cycle, publish result on leaving DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      Sum     <= '0;
      Carry   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_a     <= A;
            r_b     <= B;
            r_res   <= '0;
            r_cnt   <= '0;
            r_c     <= w_c_init;
            Busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {w_s, r_res[WIDTH-1:1]};
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          Sum     <= r_res;
          Carry   <= r_c;
          Done    <= 1'b1;
          Busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
